// File: rtl/beer_tap_arbiter.sv
// beer_tap_arbiter: shares one beer tap between N_REQ customers.
// A round-robin scan in IDLE picks the next customer and latches its level.
// The tap is then opened for level*FILL_CYCLES_PER_LEVEL tap-ready cycles,
// and the customer is acknowledged.
//
// Handshake: req[i] is level-held by customer i until it sees ack[i] (a single
// cycle pulse in DONE) or until it gives up. Dropping req[idx] while in GRANT or
// POUR aborts the pour with no ack. All outputs are decoded from registers only.
module beer_tap_arbiter #(
  parameter int N_REQ                 = 4,
  parameter int IDX_W                 = 2,
  parameter int FILL_CYCLES_PER_LEVEL = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [2*N_REQ-1:0] level,
  input  logic               tap_ready,
  output logic               pour,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   ack,
  output logic               busy,
  output logic [IDX_W-1:0]   grant_idx,
  output logic [1:0]         state_display
);

  localparam int CNT_W = $clog2(3*FILL_CYCLES_PER_LEVEL+1);
  localparam logic [IDX_W:0]   N_REQ_W  = (IDX_W+1)'(N_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ-1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_POUR  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_inc;
  logic [1:0]       lvl;
  logic [CNT_W-1:0] cnt;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic [1:0]       pick_lvl;
  logic [IDX_W:0]   scan_sum;
  logic [IDX_W-1:0] scan_j;
  logic [N_REQ-1:0] idx_onehot;
  logic             req_held;

  assign req_held = req[idx];
  assign idx_inc  = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);

  // Round-robin scan: first set req bit starting at rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    pick_lvl   = '0;
    scan_sum   = '0;
    scan_j     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      scan_sum = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (scan_sum >= N_REQ_W) scan_sum = scan_sum - N_REQ_W;
      scan_j = scan_sum[IDX_W-1:0];
      if (!pick_valid && req[scan_j]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_j;
        pick_lvl   = level[{scan_j, 1'b0} +: 2];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; an abort (req[idx] low) always wins in GRANT and POUR.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (pick_valid) state_nxt = S_GRANT;
      S_GRANT: begin
        if (!req_held)      state_nxt = S_IDLE;
        else if (lvl != 2'd0) state_nxt = S_POUR;
        else                state_nxt = S_DONE;
      end
      S_POUR: begin
        if (!req_held)                              state_nxt = S_IDLE;
        else if (tap_ready && (cnt == CNT_W'(1)))   state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: winner/level latch, pour counter and round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
      idx    <= '0;
      lvl    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            idx <= pick_idx;
            lvl <= pick_lvl;
          end
        end
        S_GRANT: begin
          if (!req_held) rr_ptr <= idx_inc;
          else           cnt    <= CNT_W'(lvl) * CNT_W'(FILL_CYCLES_PER_LEVEL);
        end
        S_POUR: begin
          if (!req_held)     rr_ptr <= idx_inc;
          else if (tap_ready) cnt   <= cnt - CNT_W'(1);
        end
        S_DONE:  rr_ptr <= idx_inc;
        default: ;
      endcase
    end
  end

  // Moore output decode from the state and the latched index.
  always_comb begin
    idx_onehot      = '0;
    idx_onehot[idx] = 1'b1;
    grant           = (state != S_IDLE) ? idx_onehot : '0;
    ack             = (state == S_DONE) ? idx_onehot : '0;
    pour            = (state == S_POUR);
    busy            = (state != S_IDLE);
    grant_idx       = idx;
    state_display   = state;
  end

endmodule

// File: tb/tb_beer_tap_arbiter.sv
// Directed bench for beer_tap_arbiter: vector table plus hand-written
// sequences for reset-release and asynchronous reset mid-pour.
module tb_beer_tap_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [7:0] level;
  logic       tap_ready;
  logic       pour;
  logic [3:0] grant;
  logic [3:0] ack;
  logic       busy;
  logic [1:0] grant_idx;
  logic [1:0] state_display;

  int checks = 0;
  int errors = 0;

  beer_tap_arbiter #(
    .N_REQ(4),
    .IDX_W(2),
    .FILL_CYCLES_PER_LEVEL(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .level(level),
    .tap_ready(tap_ready),
    .pour(pour),
    .grant(grant),
    .ack(ack),
    .busy(busy),
    .grant_idx(grant_idx),
    .state_display(state_display)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [7:0] lvl;
    logic       tr;
    logic [1:0] st;
    logic       pour;
    logic [3:0] grant;
    logic [3:0] ack;
    logic [1:0] gidx;
    string      tag;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [3:0] r, input logic [7:0] l, input logic t,
                              input logic [1:0] s, input logic p, input logic [3:0] g,
                              input logic [3:0] a, input logic [1:0] gi, input string tag);
    vec_t v;
    v.req = r; v.lvl = l; v.tr = t; v.st = s; v.pour = p;
    v.grant = g; v.ack = a; v.gidx = gi; v.tag = tag;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One active edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [1:0] st, input logic p,
                           input logic [3:0] g, input logic [3:0] a, input logic [1:0] gi,
                           input logic chk_gidx);
    check({tag, ".state"}, 32'(state_display), 32'(st));
    check({tag, ".pour"},  32'(pour), 32'(p));
    check({tag, ".grant"}, 32'(grant), 32'(g));
    check({tag, ".ack"},   32'(ack), 32'(a));
    check({tag, ".busy"},  32'(busy), 32'(st != 2'd0));
    if (chk_gidx) check({tag, ".grant_idx"}, 32'(grant_idx), 32'(gi));
  endtask

  initial begin
    int order[5];
    logic [3:0] g;
    order = '{0, 1, 2, 3, 0};

    // After reset-release grant to 0, req drops in GRANT: abort, rr_ptr -> 1.
    add(4'h0, 8'hFF, 1'b1, 2'd0, 1'b0, 4'h0, 4'h0, 2'd0, "abort_after_reset");

    // Single request from customer 1, level 2: 8 pour cycles. Level change
    // after grant is ignored. rr_ptr -> 2.
    add(4'h2, 8'h08, 1'b1, 2'd1, 1'b0, 4'h2, 4'h0, 2'd1, "single_grant");
    for (int i = 0; i < 8; i++)
      add(4'h2, 8'h0C, 1'b1, 2'd2, 1'b1, 4'h2, 4'h0, 2'd1, "single_pour");
    add(4'h2, 8'h0C, 1'b1, 2'd3, 1'b0, 4'h2, 4'h2, 2'd1, "single_done");
    add(4'h0, 8'h0C, 1'b1, 2'd0, 1'b0, 4'h0, 4'h0, 2'd1, "single_idle");

    // Abort: customer 2 drops req during the 3rd POUR cycle. rr_ptr -> 3.
    add(4'h4, 8'h30, 1'b1, 2'd1, 1'b0, 4'h4, 4'h0, 2'd2, "abort_grant");
    for (int i = 0; i < 3; i++)
      add(4'h4, 8'h30, 1'b1, 2'd2, 1'b1, 4'h4, 4'h0, 2'd2, "abort_pour");
    add(4'h0, 8'h30, 1'b1, 2'd0, 1'b0, 4'h0, 4'h0, 2'd2, "abort_idle");
    add(4'h0, 8'h30, 1'b1, 2'd0, 1'b0, 4'h0, 4'h0, 2'd2, "abort_no_ack");

    // Level 0 from customer 3: GRANT then DONE, no pour. rr_ptr -> 0.
    add(4'h8, 8'h00, 1'b1, 2'd1, 1'b0, 4'h8, 4'h0, 2'd3, "lvl0_grant");
    add(4'h8, 8'h00, 1'b1, 2'd3, 1'b0, 4'h8, 4'h8, 2'd3, "lvl0_done");
    add(4'h0, 8'h00, 1'b1, 2'd0, 1'b0, 4'h0, 4'h0, 2'd3, "lvl0_idle");

    // Round robin with all requesting at level 1: order 0,1,2,3,0. rr_ptr -> 1.
    for (int k = 0; k < 5; k++) begin
      g = 4'h1 << order[k];
      add(4'hF, 8'h55, 1'b1, 2'd1, 1'b0, g, 4'h0, 2'(order[k]), "rr_grant");
      for (int i = 0; i < 4; i++)
        add(4'hF, 8'h55, 1'b1, 2'd2, 1'b1, g, 4'h0, 2'(order[k]), "rr_pour");
      add(4'hF, 8'h55, 1'b1, 2'd3, 1'b0, g, g, 2'(order[k]), "rr_done");
      add((k == 4) ? 4'h0 : 4'hF, 8'h55, 1'b1, 2'd0, 1'b0, 4'h0, 4'h0, 2'd0, "rr_idle");
    end

    // Stall: customer 1 level 1, tap_ready low 5 cycles mid-pour -> 9 pour cycles.
    add(4'h2, 8'h04, 1'b1, 2'd1, 1'b0, 4'h2, 4'h0, 2'd1, "stall_grant");
    add(4'h2, 8'h04, 1'b1, 2'd2, 1'b1, 4'h2, 4'h0, 2'd1, "stall_pour");
    add(4'h2, 8'h04, 1'b1, 2'd2, 1'b1, 4'h2, 4'h0, 2'd1, "stall_pour");
    for (int i = 0; i < 5; i++)
      add(4'h2, 8'h04, 1'b0, 2'd2, 1'b1, 4'h2, 4'h0, 2'd1, "stall_hold");
    add(4'h2, 8'h04, 1'b1, 2'd2, 1'b1, 4'h2, 4'h0, 2'd1, "stall_pour");
    add(4'h2, 8'h04, 1'b1, 2'd2, 1'b1, 4'h2, 4'h0, 2'd1, "stall_pour");
    add(4'h2, 8'h04, 1'b1, 2'd3, 1'b0, 4'h2, 4'h2, 2'd1, "stall_done");
    add(4'h0, 8'h04, 1'b1, 2'd0, 1'b0, 4'h0, 4'h0, 2'd1, "stall_idle");

    // Reset held with every customer requesting at level 3.
    reset     = 1'b0;
    req       = 4'hF;
    level     = 8'hFF;
    tap_ready = 1'b1;
    #2;
    repeat (3) step();
    check_all("reset", 2'd0, 1'b0, 4'h0, 4'h0, 2'd0, 1'b1);

    // Release: customer 0 wins from rr_ptr=0.
    reset = 1'b1;
    step();
    check_all("reset_release", 2'd1, 1'b0, 4'h1, 4'h0, 2'd0, 1'b1);

    // Table
    foreach (vecs[n]) begin
      req       = vecs[n].req;
      level     = vecs[n].lvl;
      tap_ready = vecs[n].tr;
      step();
      check_all(vecs[n].tag, vecs[n].st, vecs[n].pour, vecs[n].grant, vecs[n].ack,
                vecs[n].gidx, vecs[n].st != 2'd0);
    end

    // Asynchronous reset in the middle of a pour (rr_ptr is 2 here).
    req       = 4'h4;
    level     = 8'h30;
    tap_ready = 1'b1;
    step();
    check_all("mid_pour_grant", 2'd1, 1'b0, 4'h4, 4'h0, 2'd2, 1'b1);
    step();
    check_all("mid_pour_pour", 2'd2, 1'b1, 4'h4, 4'h0, 2'd2, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check_all("async_reset", 2'd0, 1'b0, 4'h0, 4'h0, 2'd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
